// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad encoder.
// The state enum, matrix geometry and key-code packing live here so the
// top level and any checker agree on the encoding.
package keypad_pkg;

  localparam int KEY_W = 4;
  localparam int ROWS  = 4;
  localparam int COLS  = 4;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } state_e;

  // Key code is the row index in the upper half, column index in the lower.
  function automatic logic [KEY_W-1:0] pack_code(input logic [1:0] row,
                                                 input logic [1:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchronizer for the asynchronous, pulled-up column inputs.
// Resets to all-ones so no key appears pressed while coming out of reset.
module keypad_sync #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  // Shift the raw input through two stages to settle metastability.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_encoder.sv
// Scans a 4x4 key matrix, debounces press and release, and offers each
// accepted key as {row, col} on a single-entry valid/ready output.
// Optional feature macro: KEYPAD_AUTOREPEAT_EN (re-accepts a held key every
// REPEAT_CYC cycles). Without it, each press yields exactly one key.
//
// Handshake: key_code/key_valid form a valid/ready pair. A key is consumed
// in any cycle where key_valid and key_ready are both high; key_valid then
// drops unless a new key is accepted in that same cycle. key_code never
// changes while key_valid is high, and key_ready is ignored while
// key_valid is low. An accepted key that finds the slot occupied and not
// being consumed is dropped and flagged with a one-cycle key_overrun.
module keypad_encoder
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 16,
  parameter int DEBOUNCE_CYC = 50000,
  parameter int REPEAT_CYC   = 5000000
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [ROWS-1:0]  row_n,
  input  logic [COLS-1:0]  col_n,
  output logic [KEY_W-1:0] key_code,
  output logic             key_valid,
  input  logic             key_ready,
  output logic             key_overrun
);

  localparam int DWELL_W = $clog2(SCAN_DIV);
  localparam int DEB_W   = $clog2(DEBOUNCE_CYC);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEBOUNCE_CYC - 1);

  // Reject parameter values the counters cannot represent.
  if (SCAN_DIV < 4 || DEBOUNCE_CYC < 2 || REPEAT_CYC < 2) begin : g_bad_param
    $error("keypad_encoder: parameter out of range");
  end

  logic [COLS-1:0]    col_s;
  state_e             state_q, state_d;
  logic [1:0]         row_q, row_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [DEB_W-1:0]   deb_q, deb_d;
  logic [1:0]         cand_row_q, cand_row_d;
  logic [1:0]         cand_col_q, cand_col_d;
  logic [KEY_W-1:0]   code_q, code_d;
  logic               valid_q, valid_d;
  logic               ovr_q, ovr_d;
  logic               any_low;
  logic [1:0]         low_col;
  logic               cand_pressed;
  logic               accept;
`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int REP_W = $clog2(REPEAT_CYC);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYC - 1);
  logic [REP_W-1:0] rep_q, rep_d;
`endif

  keypad_sync #(.W(COLS)) u_sync (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .d_i    (col_n),
    .q_o    (col_s)
  );

  // Find the lowest-index low column on the currently driven row.
  always_comb begin
    any_low = 1'b0;
    low_col = 2'd0;
    for (int c = COLS - 1; c >= 0; c--) begin
      if (!col_s[c]) begin
        any_low = 1'b1;
        low_col = 2'(c);
      end
    end
  end

  assign cand_pressed = !col_s[cand_col_q];

  // Scan / debounce / held sequencing; the row only moves when leaving a
  // dwell or returning to SCAN, so it stays frozen while a key is tracked.
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    dwell_d    = dwell_q;
    deb_d      = deb_q;
    cand_row_d = cand_row_q;
    cand_col_d = cand_col_q;
    accept     = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
    rep_d      = rep_q;
`endif
    unique case (state_q)
      SCAN: begin
        if (dwell_q == DWELL_LAST) begin
          dwell_d = '0;
          if (any_low) begin
            cand_row_d = row_q;
            cand_col_d = low_col;
            deb_d      = '0;
            state_d    = DEBOUNCE;
          end else begin
            row_d = row_q + 2'd1;
          end
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end
      DEBOUNCE: begin
        if (!cand_pressed) begin
          deb_d   = '0;
          row_d   = row_q + 2'd1;
          state_d = SCAN;
        end else if (deb_q == DEB_LAST) begin
          deb_d   = '0;
          accept  = 1'b1;
          state_d = HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
          rep_d   = '0;
`endif
        end else begin
          deb_d = deb_q + 1'b1;
        end
      end
      HELD: begin
        if (cand_pressed) begin
          deb_d = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
          if (rep_q == REP_LAST) begin
            rep_d  = '0;
            accept = 1'b1;
          end else begin
            rep_d = rep_q + 1'b1;
          end
`endif
        end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
          rep_d = '0;
`endif
          if (deb_q == DEB_LAST) begin
            deb_d   = '0;
            row_d   = row_q + 2'd1;
            state_d = SCAN;
          end else begin
            deb_d = deb_q + 1'b1;
          end
        end
      end
      default: state_d = SCAN;
    endcase
  end

  // Single-entry output slot: consume on handshake, load or drop on accept.
  always_comb begin
    code_d  = code_q;
    valid_d = valid_q;
    ovr_d   = 1'b0;
    if (valid_q && key_ready) begin
      valid_d = 1'b0;
    end
    if (accept) begin
      if (!valid_q || key_ready) begin
        code_d  = pack_code(cand_row_q, cand_col_q);
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  // State, counters and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SCAN;
      row_q      <= 2'd0;
      dwell_q    <= '0;
      deb_q      <= '0;
      cand_row_q <= 2'd0;
      cand_col_q <= 2'd0;
      code_q     <= '0;
      valid_q    <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      dwell_q    <= dwell_d;
      deb_q      <= deb_d;
      cand_row_q <= cand_row_d;
      cand_col_q <= cand_col_d;
      code_q     <= code_d;
      valid_q    <= valid_d;
      ovr_q      <= ovr_d;
    end
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  // Repeat counter for held keys.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_q <= '0;
    end else begin
      rep_q <= rep_d;
    end
  end
`endif

  assign row_n       = ~(ROWS'(1) << row_q);
  assign key_code    = code_q;
  assign key_valid   = valid_q;
  assign key_overrun = ovr_q;

endmodule

// File: tb/tb_keypad_encoder.sv
// Directed bench for keypad_encoder with SCAN_DIV=4, DEBOUNCE_CYC=8,
// REPEAT_CYC=32. A small matrix model turns pressed keys into col_n from
// the driven row_n. Build with KEYPAD_AUTOREPEAT_EN to expect repeats.
`timescale 1ns/1ps
module tb_keypad_encoder;

  logic        clk;
  logic        rst_n;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_ready;
  logic        key_overrun;

  logic [15:0] pressed;

  int n_cmp = 0;
  int n_err = 0;

  // Observation log written only by the monitor.
  logic [3:0] got_mem [64];
  int got_n        = 0;
  int valid_cycles = 0;
  int ovr_cycles   = 0;

  // Scoreboard state owned by the stimulus process.
  logic [3:0] exp_q[$];
  int rd_idx = 0;

  keypad_encoder #(
    .SCAN_DIV     (4),
    .DEBOUNCE_CYC (8),
    .REPEAT_CYC   (32)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .row_n       (row_n),
    .col_n       (col_n),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .key_ready   (key_ready),
    .key_overrun (key_overrun)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Key matrix: a pressed key pulls its column low while its row is driven.
  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (!row_n[r] && pressed[r*4 + c]) col_n[c] = 1'b0;
      end
    end
  end

  // Monitor on the falling edge: log consumed keys and count valid/overrun.
  always @(negedge clk) begin
    if (rst_n) begin
      if (key_valid && key_ready) begin
        got_mem[got_n % 64] <= key_code;
        got_n <= got_n + 1;
      end
      if (key_valid)   valid_cycles <= valid_cycles + 1;
      if (key_overrun) ovr_cycles   <= ovr_cycles + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare every expected key against the consumed-key log, then the count.
  task automatic score(input string tag);
    logic [3:0]  e;
    logic [31:0] obs;
    while (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      obs = (rd_idx < got_n) ? 32'(got_mem[rd_idx % 64]) : 32'hFFFF_FFFF;
      check(tag, obs, 32'(e));
      rd_idx++;
    end
    check({tag, "_count"}, got_n, rd_idx);
    rd_idx = got_n;
  endtask

  task automatic wait_got(input int target, input int budget, input string tag);
    int k = 0;
    while (got_n < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(got_n >= target), 32'd1);
  endtask

  task automatic wait_row(input logic [3:0] row, input bit want_eq, input int budget);
    int k = 0;
    while (((row_n == row) != want_eq) && k < budget) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic drive_ready(input logic v);
    @(posedge clk);
    #1 key_ready = v;
  endtask

  initial begin
    logic [3:0] er;
    int v0;
    int o0;
    int k;

    rst_n     = 1'b0;
    key_ready = 1'b0;
    pressed   = '0;

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    check("rst_row_n", 32'(row_n), 32'hE);
    check("rst_code", 32'(key_code), 32'h0);
    check("rst_valid", 32'(key_valid), 32'h0);
    check("rst_overrun", 32'(key_overrun), 32'h0);

    // Idle scanning: each row low for 4 cycles, starting with row 0.
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      er = 4'b0001 << (i / 4);
      er = ~er;
      check("idle_row", 32'(row_n), 32'(er));
    end
    repeat (8) @(negedge clk);
    check("idle_valid", valid_cycles, 0);

    // Row 2 / col 1 with ready high: exactly one 9, valid for one cycle.
    drive_ready(1'b1);
    v0 = valid_cycles;
    pressed[9] = 1'b1;
    exp_q.push_back(4'h9);
    wait_got(rd_idx + 1, 80, "t2_wait");
    repeat (20) @(negedge clk);
    check("t2_valid_cycles", valid_cycles - v0, 1);
    check("t2_row_frozen", 32'(row_n), 32'hB);
    score("t2_key");
    pressed = '0;
    wait_row(4'b1011, 1'b0, 60);
    check("t2_resume_row3", 32'(row_n), 32'h7);

    // Bounce on row 1 / col 0: first attempt rejected, row advances.
    wait_row(4'b1101, 1'b1, 40);
    wait_row(4'b1101, 1'b0, 40);
    wait_row(4'b1101, 1'b1, 40);
    pressed[4] = 1'b1;
    repeat (5) @(negedge clk);
    pressed[4] = 1'b0;
    @(negedge clk);
    pressed[4] = 1'b1;
    repeat (2) @(negedge clk);
    check("t3_reject_row", 32'(row_n), 32'hB);
    check("t3_reject_none", got_n, rd_idx);
    exp_q.push_back(4'h4);
    wait_got(rd_idx + 1, 80, "t3_wait");
    pressed = '0;
    repeat (40) @(negedge clk);
    score("t3_key");

    // Ready low: key 3 held in slot, key C dropped with one overrun pulse.
    drive_ready(1'b0);
    pressed[3] = 1'b1;
    k = 0;
    while (!key_valid && k < 80) begin
      @(negedge clk);
      k++;
    end
    check("t4_valid_up", 32'(key_valid), 32'd1);
    pressed = '0;
    repeat (60) @(negedge clk);
    o0 = ovr_cycles;
    pressed[12] = 1'b1;
    k = 0;
    while (ovr_cycles == o0 && k < 80) begin
      @(negedge clk);
      k++;
    end
    pressed = '0;
    repeat (30) @(negedge clk);
    check("t4_code_kept", 32'(key_code), 32'h3);
    check("t4_valid_kept", 32'(key_valid), 32'd1);
    check("t4_overrun_cycles", ovr_cycles - o0, 1);
    exp_q.push_back(4'h3);
    drive_ready(1'b1);
    @(negedge clk);
    @(negedge clk);
    check("t4_valid_drop", 32'(key_valid), 32'd0);
    score("t4_key");

    // Two keys on row 0: lowest column wins.
    pressed[2] = 1'b1;
    pressed[3] = 1'b1;
    exp_q.push_back(4'h2);
    wait_got(rd_idx + 1, 80, "t5_wait");
    pressed = '0;
    repeat (40) @(negedge clk);
    score("t5_key");

    // Hold key 5 for 100 cycles after acceptance.
    pressed[5] = 1'b1;
    exp_q.push_back(4'h5);
    wait_got(rd_idx + 1, 80, "t6_wait");
    repeat (100) @(negedge clk);
`ifdef KEYPAD_AUTOREPEAT_EN
    exp_q.push_back(4'h5);
    exp_q.push_back(4'h5);
    exp_q.push_back(4'h5);
`endif
    score("t6_key");

    // Reset while the key is still held: outputs return at once.
    check("t6_row_before_rst", 32'(row_n), 32'hD);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("t6_rst_row_n", 32'(row_n), 32'hE);
    check("t6_rst_code", 32'(key_code), 32'h0);
    check("t6_rst_valid", 32'(key_valid), 32'h0);
    check("t6_rst_overrun", 32'(key_overrun), 32'h0);
    pressed = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/keypad_encoder.md
# keypad_encoder

Scans the calculator's 4x4 key matrix, debounces presses, and encodes each accepted key into the 4-bit code space that feeds the display and arithmetic path. It sits between the board keypad pins and the operand-entry logic, and is the input-side counterpart of the 4-bit display decoders. Accepted keys are offered on a single-entry valid/ready interface.

## Interface
Parameters:
- SCAN_DIV, 16: clock cycles each row is driven; must be at least 4.
- DEBOUNCE_CYC, 50000: cycles a press or release must be stable before it is accepted; must be at least 2.
- REPEAT_CYC, 5000000: auto-repeat period in cycles; used only with KEYPAD_AUTOREPEAT_EN.

Ports:
- clk, in, 1: system clock. This is the only clock.
- rst_n, in, 1: asynchronous, active-low reset.
- row_n, out, 4: row drive, active-low, exactly one bit low at a time.
- col_n, in, 4: column sense, active-low, pulled up off-chip, asynchronous to clk.
- key_code, out, 4: encoded key, {row_idx[1:0], col_idx[1:0]}.
- key_valid, out, 1: key_code holds an unconsumed key.
- key_ready, in, 1: consumer accepts key_code.
- key_overrun, out, 1: one-cycle pulse when an accepted key is dropped.

## Operation
- col_n passes through a 2-flop synchronizer. All decisions use the synchronized value col_s.
- SCAN state:
  - The current row is held low for SCAN_DIV cycles.
  - On the last dwell cycle, col_s is sampled.
  - If any column is low, the lowest-index low column and the current row are latched as the candidate. The row stays frozen and the FSM goes to DEBOUNCE.
  - Otherwise the row advances 0→1→2→3→0.
- DEBOUNCE state: the counter increments while the candidate column is low on the frozen row.
  - If that column reads high on any cycle, the counter clears and the FSM returns to SCAN with the row advanced.
  - When the counter reaches DEBOUNCE_CYC, the key is accepted and the FSM goes to HELD.
- Accept rule:
  - If key_valid=0, or key_valid=1 with key_ready=1 in the same cycle: key_code takes the candidate and key_valid=1.
  - If key_valid=1 and key_ready=0: the candidate is discarded, key_overrun pulses, and key_code is unchanged.
- HELD state: the FSM waits for the candidate column to read high for DEBOUNCE_CYC consecutive cycles.
  - Any low reading clears the release counter.
  - When the count completes, the FSM returns to SCAN with the row advanced.
- Handshake:
  - key_valid and key_ready both high in a cycle means the key is consumed, and key_valid drops the next cycle unless a new key is accepted in that same cycle.
  - key_code is stable while key_valid=1.
  - key_ready is ignored while key_valid=0.
- Multiple keys:
  - Within one row, the lowest column index wins.
  - Across rows, the first row scanned wins.
  - Other keys are ignored until the FSM is back in SCAN.
- Reset mid-operation: the FSM immediately returns to SCAN and any pending key is lost.

## Timing
- Values during and after reset:
  - row_n=4'b1110
  - key_code=4'h0
  - key_valid=0
  - key_overrun=0
  - all counters 0, FSM in SCAN
- After rst_n deasserts, row 0 dwells a full SCAN_DIV cycles.
- Press latency from stable col_n low: 2 sync cycles, plus a wait of up to 4·SCAN_DIV cycles for the row sample point, plus DEBOUNCE_CYC cycles. key_valid rises on the following clock edge.
- key_overrun is high for exactly 1 cycle per dropped key.
- row_n changes only on SCAN dwell boundaries and never while in DEBOUNCE or HELD.

## Configuration
- KEYPAD_AUTOREPEAT_EN defined:
  - In HELD, a repeat counter counts pressed cycles. Each time it reaches REPEAT_CYC, the same key_code is re-accepted under the accept rule and the counter restarts.
  - The repeat counter clears on entering HELD and on any release reading.
- Not defined: exactly one key per press, the repeat counter is absent, and REPEAT_CYC is unused.

## Structure
- Shared package keypad_pkg holds:
  - the state enum (SCAN, DEBOUNCE, HELD)
  - KEY_W=4, ROWS=4, COLS=4
  - the code packing function {row, col}
- Sub-module keypad_sync: a parameterized-width 2-flop synchronizer for col_n, reset to all-ones.
- The top-level keypad_encoder contains the FSM, the dwell, debounce and repeat counters, and the output register.

## Test plan
All scenarios use SCAN_DIV=4, DEBOUNCE_CYC=8, REPEAT_CYC=32.
- Reset, then no keys pressed: row_n cycles 1110, 1101, 1011, 0111, each for 4 cycles. key_valid stays 0.
- Hold row 2 / col 1 low, key_ready=1: exactly one key_code=4'h9 with key_valid high for 1 cycle. Release for 8 or more cycles, then scanning resumes from row 3.
- Bounce the col 0 contact low for 5 cycles, high for 1, then low steadily while row 1 is active: the first attempt is rejected and the row advances. The later stable press yields key_code=4'h4.
- key_ready=0, press key 4'h3 and release, then press key 4'hC: key_code stays 3 and key_overrun pulses once. Raising key_ready consumes 3 and key_valid drops.
- Press row 0 cols 2 and 3 together: key_code=4'h2 only.
- With KEYPAD_AUTOREPEAT_EN, hold key 4'h5 for 100 cycles after acceptance with key_ready=1: 4 total emissions of 4'h5 (initial plus 3 repeats). Assert rst_n low mid-hold: all outputs return to their reset values immediately.
